// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown cook timer.
package timer_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One packed BCD digit
    typedef logic [3:0] bcd_t;

    // Largest legal value of the seconds-tens digit and of any other digit
    localparam bcd_t MAX_SEC_TENS = 4'd5;
    localparam bcd_t MAX_DIGIT    = 4'd9;

endpackage

// File: rtl/bcd_dec_digit.sv
// Single BCD digit decrementer with borrow chain; wraps 0 to the digit's max value.
module bcd_dec_digit
    import timer_pkg::*;
(
    input  bcd_t digit_i,
    input  bcd_t max_i,
    input  logic borrow_i,
    output bcd_t digit_o,
    output logic borrow_o
);

    // Subtract the incoming borrow, wrapping and passing a borrow upward at zero
    always_comb begin
        digit_o  = digit_i;
        borrow_o = 1'b0;
        if (borrow_i) begin
            if (digit_i == 4'd0) begin
                digit_o  = max_i;
                borrow_o = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Microwave cook timer: keyed-in M:ST:SO time counted down once per second.
// Optional build macro DOOR_INTERLOCK_EN adds a door_closed input that gates
// start and pauses a running countdown when the door opens.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
`ifdef DOOR_INTERLOCK_EN
    input  logic       door_closed,
`endif
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    state_t        state_q;
    bcd_t          mins_q, tens_q, ones_q;
    bcd_t          mins_d, tens_d, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, done_q;
    logic          ones_borrow, tens_borrow, mins_borrow;
    logic          tick, time_zero, reach_zero, key_ok;
    logic          pause_req, start_ok;

    // Time value one second lower than the current one
    bcd_dec_digit u_dec_ones (
        .digit_i  (ones_q),
        .max_i    (MAX_DIGIT),
        .borrow_i (1'b1),
        .digit_o  (ones_d),
        .borrow_o (ones_borrow)
    );

    bcd_dec_digit u_dec_tens (
        .digit_i  (tens_q),
        .max_i    (MAX_SEC_TENS),
        .borrow_i (ones_borrow),
        .digit_o  (tens_d),
        .borrow_o (tens_borrow)
    );

    bcd_dec_digit u_dec_mins (
        .digit_i  (mins_q),
        .max_i    (MAX_DIGIT),
        .borrow_i (tens_borrow),
        .digit_o  (mins_d),
        .borrow_o (mins_borrow)
    );

    assign tick       = (presc_q == PRESC_LAST);
    assign presc_d    = tick ? '0 : presc_q + PW'(1);
    assign time_zero  = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
    assign reach_zero = ((mins_d == 4'd0) && (tens_d == 4'd0) && (ones_d == 4'd0)) || mins_borrow;
    assign key_ok     = (key_digit <= MAX_DIGIT) && (ones_q <= MAX_SEC_TENS);

`ifdef DOOR_INTERLOCK_EN
    assign pause_req = stop || ((state_q == ST_RUN) && !door_closed);
    assign start_ok  = start && door_closed;
`else
    assign pause_req = stop;
    assign start_ok  = start;
`endif

    // Controller FSM with prescaler, key shift register and registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mins_q    <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear) begin
                state_q   <= ST_IDLE;
                mins_q    <= '0;
                tens_q    <= '0;
                ones_q    <= '0;
                presc_q   <= '0;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        presc_q <= presc_d;
                        if (pause_req) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end else if (tick) begin
                            if (reach_zero) begin
                                mins_q    <= '0;
                                tens_q    <= '0;
                                ones_q    <= '0;
                                state_q   <= ST_DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                mins_q <= mins_d;
                                tens_q <= tens_d;
                                ones_q <= ones_d;
                            end
                        end
                    end
                    default: begin
                        if (!pause_req) begin
                            if (start_ok) begin
                                if ((state_q != ST_DONE) && !time_zero) begin
                                    state_q   <= ST_RUN;
                                    running_q <= 1'b1;
                                    if (state_q == ST_IDLE) begin
                                        presc_q <= '0;
                                    end
                                end
                            end else if (key_valid && key_ok) begin
                                mins_q  <= tens_q;
                                tens_q  <= ones_q;
                                ones_q  <= key_digit;
                                presc_q <= '0;
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign mins     = mins_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign running  = running_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer (TICKS_PER_SEC = 4).
// The reference model tracks the time as a plain count of seconds.
// Build with DOOR_INTERLOCK_EN defined to also exercise the door input.
module tb_bcd_countdown_timer;

    localparam int TICKS = 4;
`ifdef DOOR_INTERLOCK_EN
    localparam bit DOOR_EN = 1'b1;
`else
    localparam bit DOOR_EN = 1'b0;
`endif

    localparam int MS_IDLE  = 0;
    localparam int MS_RUN   = 1;
    localparam int MS_PAUSE = 2;
    localparam int MS_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       doorClosed = 1'b1;
    logic [3:0] mins, sec_tens, sec_ones;
    logic       running, done;

    int errors = 0;
    int checks = 0;

    int mState = MS_IDLE;
    int mSecs = 0;
    int mPre = 0;
    bit mDone = 1'b0;
    string curTag = "reset";

    bcd_countdown_timer #(.TICKS_PER_SEC(TICKS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
`ifdef DOOR_INTERLOCK_EN
        .door_closed (doorClosed),
`endif
        .mins        (mins),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkTime(input string tag, input int m, input int t, input int o);
        checkVal({tag, ".mins"}, mins, 4'(m));
        checkVal({tag, ".tens"}, sec_tens, 4'(t));
        checkVal({tag, ".ones"}, sec_ones, 4'(o));
    endtask

    task automatic checkFlags(input string tag, input bit run, input bit dn);
        checkVal({tag, ".running"}, {3'b0, running}, {3'b0, run});
        checkVal({tag, ".done"}, {3'b0, done}, {3'b0, dn});
    endtask

    // Compare every DUT output with the seconds-based reference model
    task automatic checkOutput();
        checkTime({"model.", curTag}, mSecs / 60, (mSecs % 60) / 10, mSecs % 10);
        checkFlags({"model.", curTag}, mState == MS_RUN, mDone);
    endtask

    task automatic modelReset();
        mState = MS_IDLE;
        mSecs  = 0;
        mPre   = 0;
        mDone  = 1'b0;
    endtask

    // One clock edge of the cook timer, from its behavioural rules
    task automatic modelStep(input logic kv, input logic [3:0] kd, input logic st,
                             input logic sp, input logic cl);
        bit doorOk;
        int onesDigit;
        int tensDigit;
        doorOk = !DOOR_EN || doorClosed;
        mDone = 1'b0;
        if (cl) begin
            mSecs  = 0;
            mPre   = 0;
            mState = MS_IDLE;
        end else if (mState == MS_RUN) begin
            mPre = (mPre + 1) % TICKS;
            if (sp || !doorOk) begin
                mState = MS_PAUSE;
            end else if (mPre == 0) begin
                mSecs = mSecs - 1;
                if (mSecs == 0) begin
                    mState = MS_DONE;
                    mDone  = 1'b1;
                end
            end
        end else if (sp) begin
            mState = mState;
        end else if (st && doorOk) begin
            if (mState != MS_DONE && mSecs != 0) begin
                if (mState == MS_IDLE) mPre = 0;
                mState = MS_RUN;
            end
        end else if (kv) begin
            onesDigit = mSecs % 10;
            tensDigit = (mSecs % 60) / 10;
            if (kd <= 4'd9 && onesDigit <= 5) begin
                mSecs  = tensDigit * 60 + onesDigit * 10 + int'(kd);
                mState = MS_IDLE;
                mPre   = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check
    task automatic applyStimulus(input logic kv, input logic [3:0] kd, input logic st,
                                 input logic sp, input logic cl);
        key_valid = kv;
        key_digit = kd;
        start     = st;
        stop      = sp;
        clear     = cl;
        @(posedge clk);
        modelStep(kv, kd, st, sp, cl);
        #1;
        checkOutput();
        key_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic key(input int d);
        applyStimulus(1'b1, 4'(d), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        modelReset();
        #12;
        curTag = "reset";
        checkTime("reset", 0, 0, 0);
        checkFlags("reset", 1'b0, 1'b0);
        rst_n = 1'b1;

        curTag = "keys";
        key(1); key(3); key(0);
        checkTime("keys130", 1, 3, 0);
        key(7); key(9);
        checkTime("keyReject", 3, 0, 7);
        key(12);
        checkTime("keyIllegal", 3, 0, 7);

        curTag = "count2";
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        key(0); key(2);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkFlags("startRun", 1'b1, 1'b0);
        idle(3);
        checkTime("noTickYet", 0, 0, 2);
        idle(1);
        checkTime("firstTick", 0, 0, 1);
        idle(4);
        checkTime("zero", 0, 0, 0);
        checkFlags("donePulse", 1'b0, 1'b1);
        idle(1);
        checkFlags("doneOnce", 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkFlags("startInDone", 1'b0, 1'b0);
        key(4);
        checkTime("keyFromDone", 0, 0, 4);

        curTag = "borrow";
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        key(1); key(0); key(0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(4);
        checkTime("doubleBorrow", 0, 5, 9);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checkFlags("clearRun", 1'b0, 1'b0);
        key(1); key(0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(4);
        checkTime("tensBorrow", 0, 0, 9);

        curTag = "startRules";
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkFlags("startZero", 1'b0, 1'b0);
        key(5);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        checkFlags("startStop", 1'b0, 1'b0);
        checkTime("startStopTime", 0, 0, 5);

        curTag = "pause";
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checkFlags("paused", 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkFlags("resumed", 1'b1, 1'b0);
        idle(1);
        checkTime("resumeHold", 0, 0, 5);
        idle(1);
        checkTime("resumeTick", 0, 0, 4);

        curTag = "asyncReset";
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkTime("asyncReset", 0, 0, 0);
        checkFlags("asyncReset", 1'b0, 1'b0);
        #1 rst_n = 1'b1;

`ifdef DOOR_INTERLOCK_EN
        curTag = "door";
        key(3);
        doorClosed = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkFlags("doorBlocksStart", 1'b0, 1'b0);
        doorClosed = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkFlags("doorStart", 1'b1, 1'b0);
        idle(2);
        doorClosed = 1'b0;
        idle(1);
        checkFlags("doorOpenPause", 1'b0, 1'b0);
        idle(5);
        checkTime("doorHeld", 0, 0, 3);
        doorClosed = 1'b1;
`endif

        curTag = "random";
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            if (DOOR_EN) doorClosed = ($urandom_range(0, 9) != 0);
            applyStimulus($urandom_range(0, 3) == 0,
                          4'($urandom_range(0, 11)),
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 24) == 0,
                          $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
